// File: rtl/button_debounce_accum.sv
// Button/switch input conditioning: synchronises sw and the push button, debounces
// the button, adds sw into an 8-bit accumulator per press, clears it on long press.
module button_debounce_accum #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int HOLD_CYCLES     = 6000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sw,
    input  logic       switch,
    output logic [7:0] value,
    output logic       press_pulse,
    output logic       clear_pulse,
    output logic       overflow,
    output logic       btn_level
);

    localparam int CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    // The long-press time includes the confirmation window already spent.
    localparam logic [HOLD_W-1:0] HOLD_ENTRY = HOLD_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_FIRE  = HOLD_W'(HOLD_CYCLES - 2);

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'd0,
        ST_CONFIRM_PRESS   = 2'd1,
        ST_PRESSED         = 2'd2,
        ST_CONFIRM_RELEASE = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0]      btn_sync_q;
    logic [SYNC_STAGES-1:0][7:0] sw_sync_q;
    logic                        btn_s;
    logic [7:0]                  sw_s;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_pulse_q, press_pulse_d;
    logic              clear_pulse_q, clear_pulse_d;
    logic [7:0]        value_q, value_d;
    logic              overflow_q, overflow_d;
    logic              btn_level_q, btn_level_d;
    logic [8:0]        sum_s;

    assign btn_s = btn_sync_q[SYNC_STAGES-1];
    assign sw_s  = sw_sync_q[SYNC_STAGES-1];

    // Synchroniser shift chains for the asynchronous button and switches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync_q <= '0;
            sw_sync_q  <= '0;
        end else begin
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], switch};
            sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], sw};
        end
    end

    // Debounce FSM next state, counters and pulse requests.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hold_d        = hold_q;
        press_pulse_d = 1'b0;
        clear_pulse_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (btn_s) begin
                    state_d = ST_CONFIRM_PRESS;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_CONFIRM_PRESS: begin
                if (!btn_s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d       = ST_PRESSED;
                    cnt_d         = '0;
                    hold_d        = HOLD_ENTRY;
                    press_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_d = ST_CONFIRM_RELEASE;
                    cnt_d   = CNT_ONE;
                end else if (hold_q != HOLD_LAST) begin
                    // Fires only on the step into the saturated value: once per press.
                    hold_d        = hold_q + HOLD_ONE;
                    clear_pulse_d = (hold_q == HOLD_FIRE);
                end else begin
                    hold_d = hold_q;
                end
            end
            ST_CONFIRM_RELEASE: begin
                if (btn_s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                    hold_d  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Accumulator update driven by the registered press/clear strobes.
    always_comb begin
        sum_s       = {1'b0, value_q} + {1'b0, sw_s};
        value_d     = value_q;
        overflow_d  = overflow_q;
        btn_level_d = (state_d == ST_PRESSED) || (state_d == ST_CONFIRM_RELEASE);
        if (clear_pulse_q) begin
            value_d    = 8'h00;
            overflow_d = 1'b0;
        end else if (press_pulse_q) begin
            value_d    = sum_s[7:0];
            overflow_d = overflow_q | sum_s[8];
        end else begin
            value_d    = value_q;
            overflow_d = overflow_q;
        end
    end

    // State, counters and all output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RELEASED;
            cnt_q         <= '0;
            hold_q        <= '0;
            press_pulse_q <= 1'b0;
            clear_pulse_q <= 1'b0;
            value_q       <= 8'h00;
            overflow_q    <= 1'b0;
            btn_level_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hold_q        <= hold_d;
            press_pulse_q <= press_pulse_d;
            clear_pulse_q <= clear_pulse_d;
            value_q       <= value_d;
            overflow_q    <= overflow_d;
            btn_level_q   <= btn_level_d;
        end
    end

    assign value       = value_q;
    assign press_pulse = press_pulse_q;
    assign clear_pulse = clear_pulse_q;
    assign overflow    = overflow_q;
    assign btn_level   = btn_level_q;

endmodule
